// File: rtl/tl_a_channel_arbiter.sv
// Two-requester TileLink-UL A-channel arbiter with D-channel return routing.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | free arbitration; grant picked combinationally each cycle
//   S_HOLD  | granted beat stalled by o_ready; grant frozen until it fires
//   S_BURST | multi-beat Put in flight; grant locked until the last beat
module tl_a_channel_arbiter #(
  parameter int SRC_W  = 4,
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a0_valid,
  output logic                  a0_ready,
  input  logic [2:0]            a0_opcode,
  input  logic [2:0]            a0_param,
  input  logic [3:0]            a0_size,
  input  logic [SRC_W-1:0]      a0_source,
  input  logic [31:0]           a0_address,
  input  logic [DATA_W/8-1:0]   a0_mask,
  input  logic [DATA_W-1:0]     a0_data,
  input  logic                  a0_corrupt,
  input  logic                  a1_valid,
  output logic                  a1_ready,
  input  logic [2:0]            a1_opcode,
  input  logic [2:0]            a1_param,
  input  logic [3:0]            a1_size,
  input  logic [SRC_W-1:0]      a1_source,
  input  logic [31:0]           a1_address,
  input  logic [DATA_W/8-1:0]   a1_mask,
  input  logic [DATA_W-1:0]     a1_data,
  input  logic                  a1_corrupt,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [2:0]            o_opcode,
  output logic [2:0]            o_param,
  output logic [3:0]            o_size,
  output logic [SRC_W:0]        o_source,
  output logic [31:0]           o_address,
  output logic [DATA_W/8-1:0]   o_mask,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_corrupt,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [SRC_W:0]        d_source,
  output logic                  d0_valid,
  input  logic                  d0_ready,
  output logic                  d1_valid,
  input  logic                  d1_ready,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_BURST} state_t;

  state_t     r_state;
  logic       r_grant;
  logic       r_last;
  logic [7:0] r_beats;
  logic       r_err;

  logic       w_gnt;
  logic       w_sel_valid;
  logic       w_fire;
  logic       w_multi;
  logic       w_illegal;
  logic [8:0] w_beats;
  logic [8:0] w_beats_m1;
  logic       w_d_idx;
  logic       w_unused_d_src;

  // Grant choice: round-robin in IDLE, frozen on r_grant otherwise; forward the winner.
  always_comb begin
    if (r_state == S_IDLE)
      w_gnt = a1_valid & (~a0_valid | ~r_last);
    else
      w_gnt = r_grant;
    w_sel_valid = w_gnt ? a1_valid   : a0_valid;
    o_opcode    = w_gnt ? a1_opcode  : a0_opcode;
    o_param     = w_gnt ? a1_param   : a0_param;
    o_size      = w_gnt ? a1_size    : a0_size;
    o_source    = {w_gnt, (w_gnt ? a1_source : a0_source)};
    o_address   = w_gnt ? a1_address : a0_address;
    o_mask      = w_gnt ? a1_mask    : a0_mask;
    o_data      = w_gnt ? a1_data    : a0_data;
    o_corrupt   = w_gnt ? a1_corrupt : a0_corrupt;
    // Handshake outputs are forced low while reset is held.
    o_valid     = reset_n & w_sel_valid;
    a0_ready    = reset_n & o_ready & ~w_gnt;
    a1_ready    = reset_n & o_ready & w_gnt;
    w_fire      = o_valid & o_ready;
  end

  // Burst length of the beat being presented; oversized Puts run as 256 beats.
  always_comb begin
    w_multi    = ((o_opcode == 3'd0) || (o_opcode == 3'd1)) && (o_size > 4'd3);
    w_illegal  = w_multi && (o_size > 4'd11);
    w_beats    = w_illegal ? 9'd256 : (9'd1 << (o_size - 4'd3));
    w_beats_m1 = w_beats - 9'd1;
  end

  // D return: the top source bit is the requester tag; the low bits belong to the requester.
  always_comb begin
    w_d_idx        = d_source[SRC_W];
    d0_valid       = reset_n & d_valid & ~w_d_idx;
    d1_valid       = reset_n & d_valid & w_d_idx;
    d_ready        = reset_n & (w_d_idx ? d1_ready : d0_ready);
    w_unused_d_src = ^d_source[SRC_W-1:0];
  end

  assign err = r_err;

  // Arbitration state machine: stall hold, burst lock and sticky size error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_fire) begin
            r_last <= w_gnt;
            if (w_multi) begin
              r_beats <= w_beats_m1[7:0];
              r_grant <= w_gnt;
              r_state <= S_BURST;
              if (w_illegal) r_err <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (o_valid) begin
            r_grant <= w_gnt;
            r_state <= S_HOLD;
          end
        end
        S_BURST: begin
          if (w_fire) begin
            r_beats <= r_beats - 8'd1;
            if (r_beats == 8'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tl_a_channel_arbiter.sv
// Bench for tl_a_channel_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration rules.
module tb_tl_a_channel_arbiter;
  localparam int SRC_W = 4;
  localparam int DATA_W = 64;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic a0_valid, a0_ready, a0_corrupt;
  logic [2:0] a0_opcode, a0_param;
  logic [3:0] a0_size;
  logic [SRC_W-1:0] a0_source;
  logic [31:0] a0_address;
  logic [DATA_W/8-1:0] a0_mask;
  logic [DATA_W-1:0] a0_data;
  logic a1_valid, a1_ready, a1_corrupt;
  logic [2:0] a1_opcode, a1_param;
  logic [3:0] a1_size;
  logic [SRC_W-1:0] a1_source;
  logic [31:0] a1_address;
  logic [DATA_W/8-1:0] a1_mask;
  logic [DATA_W-1:0] a1_data;
  logic o_valid, o_ready, o_corrupt;
  logic [2:0] o_opcode, o_param;
  logic [3:0] o_size;
  logic [SRC_W:0] o_source;
  logic [31:0] o_address;
  logic [DATA_W/8-1:0] o_mask;
  logic [DATA_W-1:0] o_data;
  logic d_valid, d_ready, d0_valid, d0_ready, d1_valid, d1_ready, err;
  logic [SRC_W:0] d_source;

  int n_tests = 0;
  int n_fail = 0;

  tl_a_channel_arbiter #(.SRC_W(SRC_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .a0_valid(a0_valid), .a0_ready(a0_ready), .a0_opcode(a0_opcode), .a0_param(a0_param),
    .a0_size(a0_size), .a0_source(a0_source), .a0_address(a0_address), .a0_mask(a0_mask),
    .a0_data(a0_data), .a0_corrupt(a0_corrupt),
    .a1_valid(a1_valid), .a1_ready(a1_ready), .a1_opcode(a1_opcode), .a1_param(a1_param),
    .a1_size(a1_size), .a1_source(a1_source), .a1_address(a1_address), .a1_mask(a1_mask),
    .a1_data(a1_data), .a1_corrupt(a1_corrupt),
    .o_valid(o_valid), .o_ready(o_ready), .o_opcode(o_opcode), .o_param(o_param),
    .o_size(o_size), .o_source(o_source), .o_address(o_address), .o_mask(o_mask),
    .o_data(o_data), .o_corrupt(o_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_source(d_source),
    .d0_valid(d0_valid), .d0_ready(d0_ready), .d1_valid(d1_valid), .d1_ready(d1_ready),
    .err(err)
  );

  task automatic idle_inputs();
    a0_valid = 0; a0_opcode = 0; a0_param = 0; a0_size = 0; a0_source = 0;
    a0_address = 0; a0_mask = 0; a0_data = 0; a0_corrupt = 0;
    a1_valid = 0; a1_opcode = 0; a1_param = 0; a1_size = 0; a1_source = 0;
    a1_address = 0; a1_mask = 0; a1_data = 0; a1_corrupt = 0;
    o_ready = 0; d_valid = 0; d_source = 0; d0_ready = 0; d1_ready = 0;
  endtask

  task automatic set_a0(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src);
    a0_opcode = op; a0_size = sz; a0_source = src; a0_mask = 8'hFF; a0_address = 32'h1000;
  endtask

  task automatic set_a1(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src);
    a1_opcode = op; a1_size = sz; a1_source = src; a1_mask = 8'hFF; a1_address = 32'h2000;
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks who owns the channel (stalled beat or burst), remaining burst beats,
  // and the last winner, at the level of transactions rather than RTL states.
  bit m_locked, m_burst, m_err;
  int m_owner, m_left, m_last;
  logic [2:0] g_op[2];
  logic [3:0] g_sz[2];
  logic [3:0] g_src[2];
  logic [63:0] g_dat[2];
  bit g_v[2];
  int g_rem[2];

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
    if (op <= 3'd1 && sz > 4'd3) return (sz > 4'd11) ? 256 : (1 << (int'(sz) - 3));
    return 1;
  endfunction

  function automatic void model_sel(output bit v, output int g);
    if (m_locked) begin g = m_owner; v = g_v[g]; end
    else if (g_v[0] && g_v[1]) begin g = 1 - m_last; v = 1; end
    else if (g_v[0]) begin g = 0; v = 1; end
    else if (g_v[1]) begin g = 1; v = 1; end
    else begin g = 0; v = 0; end
  endfunction

  function automatic void model_advance(input bit v, input int g, input bit rdy);
    int n;
    if (v && rdy) begin
      if (!m_burst) begin
        m_last = g;
        n = beats_of(g_op[g], g_sz[g]);
        if (g_op[g] <= 3'd1 && g_sz[g] > 4'd11) m_err = 1;
        if (n > 1) begin m_burst = 1; m_locked = 1; m_owner = g; m_left = n - 1; end
        else m_locked = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin m_burst = 0; m_locked = 0; end
      end
    end else if (v && !m_burst) begin
      m_locked = 1; m_owner = g;
    end
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    a0_valid = 1; a1_valid = 1; o_ready = 1; d_valid = 1; d_source = 5'h13; d0_ready = 1; d1_ready = 1;
    #1;
    n_tests++;
    if ({o_valid, a0_ready, a1_ready, d0_valid, d1_valid, d_ready, err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {o_valid, a0_ready, a1_ready, d0_valid, d1_valid, d_ready, err});
    end
    @(negedge clock);
    idle_inputs();
    reset_n = 1;
    @(negedge clock);
    #1;
    n_tests++;
    if ({o_valid, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_release_idle: got o_valid/err %b required 00", {o_valid, err});
    end
    @(negedge clock);
  endtask

  task automatic test_alternation();
    logic [4:0] exp_src;
    logic exp_r0;
    set_a0(3'd4, 4'd3, 4'h5); set_a1(3'd4, 4'd3, 4'h9);
    a0_valid = 1; a1_valid = 1; o_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_r0 = (i % 2 == 0);
      exp_src = exp_r0 ? 5'h05 : 5'h19;
      n_tests++;
      if ({o_valid, o_source, a0_ready, a1_ready} !== {1'b1, exp_src, exp_r0, ~exp_r0}) begin
        n_fail++;
        $display("FAIL alternation[%0d]: got v=%b src=%h r0=%b r1=%b required v=1 src=%h r0=%b r1=%b",
                 i, o_valid, o_source, a0_ready, a1_ready, exp_src, exp_r0, ~exp_r0);
      end
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_burst_lock();
    set_a0(3'd0, 4'd5, 4'h2); set_a1(3'd4, 4'd3, 4'h7);
    a0_valid = 1; a1_valid = 1; o_ready = 1;
    for (int b = 0; b < 4; b++) begin
      a0_data = 64'(b) + 64'h100;
      #1;
      n_tests++;
      if ({o_valid, o_source, o_data, a0_ready, a1_ready} !== {1'b1, 5'h02, 64'(b) + 64'h100, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL burst_beat[%0d]: got v=%b src=%h data=%h r0=%b r1=%b required v=1 src=02 data=%h r0=1 r1=0",
                 b, o_valid, o_source, o_data, a0_ready, a1_ready, 64'(b) + 64'h100);
      end
      @(negedge clock);
    end
    a0_valid = 0;
    #1;
    n_tests++;
    if ({o_valid, o_source, a0_ready, a1_ready} !== {1'b1, 5'h17, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL burst_then_a1: got v=%b src=%h r0=%b r1=%b required v=1 src=17 r0=0 r1=1",
               o_valid, o_source, a0_ready, a1_ready);
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_hold();
    set_a1(3'd4, 4'd3, 4'h3); a1_valid = 1; o_ready = 0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) begin set_a0(3'd4, 4'd3, 4'h4); a0_valid = 1; end
      #1;
      n_tests++;
      if ({o_valid, o_source, a0_ready, a1_ready} !== {1'b1, 5'h13, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL hold_stall[%0d]: got v=%b src=%h r0=%b r1=%b required v=1 src=13 r0=0 r1=0",
                 c, o_valid, o_source, a0_ready, a1_ready);
      end
      @(negedge clock);
    end
    o_ready = 1;
    #1;
    n_tests++;
    if ({o_valid, o_source, a0_ready, a1_ready} !== {1'b1, 5'h13, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_fire: got v=%b src=%h r0=%b r1=%b required v=1 src=13 r0=0 r1=1",
               o_valid, o_source, a0_ready, a1_ready);
    end
    @(negedge clock);
    a1_valid = 0;
    #1;
    n_tests++;
    if ({o_valid, o_source, a0_ready, a1_ready} !== {1'b1, 5'h04, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_then_a0: got v=%b src=%h r0=%b r1=%b required v=1 src=04 r0=1 r1=0",
               o_valid, o_source, a0_ready, a1_ready);
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_illegal_size();
    int bad;
    bad = 0;
    set_a0(3'd1, 4'd12, 4'h6); a0_valid = 1; o_ready = 1; a0_data = 64'd0;
    #1;
    n_tests++;
    if ({err, o_valid, o_source} !== {1'b0, 1'b1, 5'h06}) begin
      n_fail++;
      $display("FAIL err_first_beat: got err=%b v=%b src=%h required err=0 v=1 src=06", err, o_valid, o_source);
    end
    @(negedge clock);
    set_a1(3'd4, 4'd3, 4'h8); a1_valid = 1;
    for (int b = 1; b < 256; b++) begin
      a0_data = 64'(b);
      #1;
      if (b == 1) begin
        n_tests++;
        if (err !== 1'b1) begin
          n_fail++;
          $display("FAIL err_set: got %b required 1", err);
        end
      end
      if ({o_valid, o_source, o_data, a1_ready} !== {1'b1, 5'h06, 64'(b), 1'b0}) bad++;
      @(negedge clock);
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL err_256_beats: got %0d bad beats required 0", bad);
    end
    a0_valid = 0;
    #1;
    n_tests++;
    if ({o_valid, o_source, a1_ready, err} !== {1'b1, 5'h18, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL err_after_burst: got v=%b src=%h r1=%b err=%b required v=1 src=18 r1=1 err=1",
               o_valid, o_source, a1_ready, err);
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_d_routing();
    logic [2:0] exp[5];
    exp[0] = 3'b010; exp[1] = 3'b011; exp[2] = 3'b100; exp[3] = 3'b101; exp[4] = 3'b001;
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin d_valid = 1; d_source = 5'h13; d1_ready = 0; d0_ready = 1; end
        1: d1_ready = 1;
        2: begin d_source = 5'h02; d0_ready = 0; end
        3: d0_ready = 1;
        default: d_valid = 0;
      endcase
      #1;
      n_tests++;
      if ({d0_valid, d1_valid, d_ready} !== exp[s]) begin
        n_fail++;
        $display("FAIL d_route[%0d]: got d0v/d1v/dr=%b required %b", s, {d0_valid, d1_valid, d_ready}, exp[s]);
      end
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_burst();
    set_a0(3'd0, 4'd6, 4'h1); set_a1(3'd4, 4'd3, 4'hA);
    a0_valid = 1; a1_valid = 1; o_ready = 1;
    for (int b = 0; b < 2; b++) begin
      #1;
      n_tests++;
      if ({o_valid, o_source} !== {1'b1, 5'h01}) begin
        n_fail++;
        $display("FAIL mid_burst_beat[%0d]: got v=%b src=%h required v=1 src=01", b, o_valid, o_source);
      end
      @(negedge clock);
    end
    reset_n = 0; d_valid = 1; d_source = 5'h10; d1_ready = 1;
    #1;
    n_tests++;
    if ({o_valid, a0_ready, a1_ready, d0_valid, d1_valid, d_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_burst_reset: got %b required 000000",
               {o_valid, a0_ready, a1_ready, d0_valid, d1_valid, d_ready});
    end
    @(negedge clock);
    reset_n = 1; a0_valid = 0; d_valid = 0;
    #1;
    n_tests++;
    if ({o_valid, o_source, a1_ready, err} !== {1'b1, 5'h1A, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL post_reset_a1: got v=%b src=%h r1=%b err=%b required v=1 src=1a r1=1 err=0",
               o_valid, o_source, a1_ready, err);
    end
    @(negedge clock);
    a1_valid = 0; set_a0(3'd4, 4'd3, 4'h1); a0_valid = 1;
    #1;
    n_tests++;
    if ({o_valid, o_source, a0_ready} !== {1'b1, 5'h01, 1'b1}) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b src=%h r0=%b required v=1 src=01 r0=1",
               o_valid, o_source, a0_ready);
    end
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
  endtask

  // ---------------- randomized run against the model ----------------
  task automatic test_random();
    bit ev;
    int eg;
    int bad_a, bad_d, bad_e;
    logic [4:0] exp_src;
    bad_a = 0; bad_d = 0; bad_e = 0;
    idle_inputs();
    reset_n = 0;
    #1;
    @(negedge clock);
    reset_n = 1;
    m_locked = 0; m_burst = 0; m_err = 0; m_owner = 0; m_left = 0; m_last = 1;
    for (int r = 0; r < 2; r++) begin g_v[r] = 0; g_rem[r] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!g_v[r] && $urandom_range(3) != 0) begin
          if (g_rem[r] == 0) begin
            case ($urandom_range(2))
              0: g_op[r] = 3'd0;
              1: g_op[r] = 3'd1;
              default: g_op[r] = 3'd4;
            endcase
            g_sz[r] = 4'($urandom_range(6));
            g_src[r] = 4'($urandom);
            g_rem[r] = beats_of(g_op[r], g_sz[r]);
          end
          g_v[r] = 1;
          g_dat[r] = {$urandom, $urandom};
        end
      end
      a0_valid = g_v[0]; a0_opcode = g_op[0]; a0_size = g_sz[0]; a0_source = g_src[0]; a0_data = g_dat[0];
      a1_valid = g_v[1]; a1_opcode = g_op[1]; a1_size = g_sz[1]; a1_source = g_src[1]; a1_data = g_dat[1];
      o_ready = ($urandom_range(9) < 7);
      d_valid = 1'($urandom); d_source = 5'($urandom); d0_ready = 1'($urandom); d1_ready = 1'($urandom);
      #1;
      model_sel(ev, eg);
      exp_src = {1'(eg), g_src[eg]};
      n_tests++;
      if (o_valid !== ev ||
          (ev && ({o_source, o_data, o_opcode, o_size, a0_ready, a1_ready} !==
                  {exp_src, g_dat[eg], g_op[eg], g_sz[eg], (eg == 0) & o_ready, (eg == 1) & o_ready}))) begin
        n_fail++;
        if (bad_a < 5)
          $display("FAIL random_a[%0d]: got v=%b src=%h r0=%b r1=%b required v=%b src=%h r0=%b r1=%b",
                   cyc, o_valid, o_source, a0_ready, a1_ready, ev, exp_src,
                   (eg == 0) & o_ready, (eg == 1) & o_ready);
        bad_a++;
      end
      n_tests++;
      if ({d0_valid, d1_valid, d_ready} !==
          {d_valid & ~d_source[4], d_valid & d_source[4], d_source[4] ? d1_ready : d0_ready}) begin
        n_fail++;
        if (bad_d < 5)
          $display("FAIL random_d[%0d]: got %b for d_valid=%b d_source=%h", cyc,
                   {d0_valid, d1_valid, d_ready}, d_valid, d_source);
        bad_d++;
      end
      n_tests++;
      if (err !== m_err) begin
        n_fail++;
        if (bad_e < 5) $display("FAIL random_err[%0d]: got %b required %b", cyc, err, m_err);
        bad_e++;
      end
      if (ev && o_ready) begin
        g_v[eg] = 0;
        g_rem[eg]--;
      end
      model_advance(ev, eg, o_ready);
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_burst_lock();
    test_hold();
    test_illegal_size();
    test_d_routing();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_a_channel_arbiter.md
# tl_a_channel_arbiter

Two-requester TileLink-UL arbiter that shares one downstream A channel (address/data toward the memory-side port covered by the TL monitor) and routes the D-channel response back to the originating requester. Round-robin between requesters, grant locked for the full multi-beat Put burst, grant held stable while the downstream stalls. Source IDs are widened by one bit to tag the requester.

## Interface
- `SRC_W`, 4, requester source-ID width; output source is `SRC_W+1`
- `DATA_W`, 64, data width; beat size 8 bytes, mask width `DATA_W/8`
- `clock`  in  1  sole clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `a0_valid/a0_ready`  in/out  1/1  requester 0 A handshake
- `a0_opcode, a0_param`  in  3, 3  A opcode/param
- `a0_size`  in  4  log2 transfer bytes
- `a0_source`  in  SRC_W  requester source ID
- `a0_address`  in  32  byte address
- `a0_mask, a0_data, a0_corrupt`  in  8, DATA_W, 1  write beat payload
- `a1_*`  same as `a0_*`  requester 1
- `o_valid/o_ready`  out/in  1/1  downstream A handshake
- `o_opcode, o_param, o_size, o_address, o_mask, o_data, o_corrupt`  out  as above  forwarded fields
- `o_source`  out  SRC_W+1  `{grant_idx, a<grant>_source}`
- `d_valid/d_ready`  in/out  1/1  downstream D handshake; `d_source` in SRC_W+1
- `d0_valid, d1_valid`  out  1  D valid to requester; `d0_ready, d1_ready` in 1
- `err`  out  1  sticky protocol error (illegal burst size)

## Operation
- States: IDLE, HOLD, BURST. Registers: `state`, `grant_q`, `last_q`, `beats_q[7:0]`, `err`.
- IDLE: grant combinational. Only one valid → that one. Both valid → requester ≠ `last_q`. Neither → `o_valid`=0.
- Multi-beat: opcode 0 (PutFull) or 1 (PutPartial) with size>3; beats = 1<<(size-3). Size>11 illegal: `err` set, treated as 256 beats. All other opcodes/sizes single-beat.
- Forwarding: `o_*` = granted requester's fields; `a<g>_ready = o_ready`; non-granted `ready`=0.
- Fire (`o_valid & o_ready`) in IDLE/HOLD: `last_q<=g`. Multi-beat → `beats_q<=beats-1`, `grant_q<=g`, BURST; else IDLE.
- IDLE/HOLD with `o_valid & !o_ready` (no fire): `grant_q<=g`, HOLD. HOLD forwards only `grant_q`, no re-arbitration.
- BURST: forward only `grant_q`, other ready 0. Each fire decrements `beats_q`; fire at `beats_q==1` → IDLE. Requester valid low mid-burst: wait, no timeout.
- D routing (combinational): `idx=d_source[SRC_W]`; `d<idx>_valid=d_valid`, other 0; `d_ready=d<idx>_ready`. D path is independent of A state.
- `err` clears only on reset.

## Timing
- Reset (async assert, sync-released by the system): `state`=IDLE, `grant_q`=0, `last_q`=1 (requester 0 wins first tie), `beats_q`=0, `err`=0. While `reset_n` low, `o_valid`, `a0_ready`, `a1_ready`, `d0_valid`, `d1_valid`, `d_ready` are all 0.
- Zero-cycle A and D latency; no output registers. `o_valid` never depends on `o_ready`.
- Single-beat back-to-back: one fire per cycle. Alternation under continuous contention.
- Simultaneous new valid on the other requester during HOLD/BURST: ignored until return to IDLE.
- Burst last beat fire and new requests in same cycle: arbitration resumes next cycle using the updated `last_q`.
- Reset mid-burst: state lost, IDLE. Partial burst is not resumed.

## Test plan
- Both requesters continuously valid, Get size 3, `o_ready`=1 → grants 0,1,0,1; `o_source` = 0x0s,0x1s alternating.
- a0 PutFull size 5 (4 beats), a1 valid throughout → 4 consecutive a0 beats, then a1; a1_ready=0 during burst.
- a1 valid alone, `o_ready`=0 for 3 cycles, a0 asserts cycle 2 → output stays a1 until fire, then a0.
- PutPartial size 12 → `err`=1 next cycle and sticky, 256 beats forwarded, then IDLE.
- `d_source`=0x13, `d1_ready`=0 then 1 → `d1_valid`=1, `d0_valid`=0, `d_ready` follows `d1_ready`.
- Assert `reset_n`=0 after beat 2 of an 8-beat burst → all valid/ready outputs 0 immediately; after release, a1 alone granted single-beat correctly, `err`=0.
